pll_lock_supervisor: RTL and testbench

- Parametrised successor to the team's fixed PLL wrapper; sits directly behind the ECP5 PLL.
- Synchronises the raw PLL lock and requires lock to stay stable for a set time.
- Releases NUM_DOM per-domain resets in a staged order.
- Detects and counts lock loss, and re-requests a PLL reset when lock never arrives.

---
 rtl/pll_lock_supervisor.sv | 236 +++++++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// Purpose: supervises the ECP5 PLL lock, releases NUM_DOM domain resets in stages, and counts lock losses.
// Latency: locked_in is synchronised through 2 flops; a lock loss reaches the outputs 3 edges after locked_in falls (FILTER_CYCLES+2 with the filter).
// Backpressure: none; clr_count is a one-cycle strobe; optional loss debounce enabled by macro GLITCH_FILTER_EN.
module pll_lock_supervisor #(
  parameter int NUM_DOM       = 3,
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGE_GAP     = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int PLLRST_CYCLES = 32,
  parameter int LOSS_CNT_W    = 8,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                  clki,
  input  logic                  rstn,
  input  logic                  locked_in,
  input  logic                  clr_count,
  output logic                  pll_rst,
  output logic [NUM_DOM-1:0]    dom_rstn,
  output logic                  all_ready,
  output logic                  lock_lost,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Terminal values of the shared phase timer, one per state that counts.
  localparam int PLL_LAST_I = PLLRST_CYCLES - 1;
  localparam int TMO_LAST_I = LOCK_TIMEOUT - 1;
  localparam int STB_LAST_I = STABLE_CYCLES - 1;
  localparam int REL_LAST_I = (NUM_DOM - 1) * STAGE_GAP;
  localparam int TMR_MAX    = max_i(max_i(PLL_LAST_I, TMO_LAST_I), max_i(STB_LAST_I, REL_LAST_I));
  localparam int TMR_W      = (TMR_MAX < 1) ? 1 : $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] PLL_LAST = TMR_W'(PLL_LAST_I);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TMO_LAST_I);
  localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STB_LAST_I);
  localparam logic [TMR_W-1:0] REL_LAST = TMR_W'(REL_LAST_I);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic                    pll_rst_q, pll_rst_d;
  logic [NUM_DOM-1:0]      dom_rstn_q, dom_rstn_d;
  logic                    all_ready_q, all_ready_d;
  logic                    lock_lost_q, lock_lost_d;
  logic [LOSS_CNT_W-1:0]   loss_cnt_q, loss_cnt_d;

  logic                    lock_meta_q;
  logic                    lock_s_q;
  logic                    loss_det;
  logic                    loss_ev;

`ifdef GLITCH_FILTER_EN
  localparam int FLT_W = (FILTER_CYCLES <= 1) ? 1 : $clog2(FILTER_CYCLES);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_CYCLES - 1);

  logic [FLT_W-1:0]        filt_q, filt_d;

  // A loss only counts once lock_s has been low for FILTER_CYCLES cycles in a row.
  assign loss_det = !lock_s_q && (filt_q == FLT_LAST);
`else
  logic                    unused_filter_cfg;

  // Without the filter any single low cycle of lock_s is a loss.
  assign loss_det = !lock_s_q;
  assign unused_filter_cfg = (FILTER_CYCLES > 0);
`endif

  // Two-flop synchroniser for the raw PLL lock, which is asynchronous to clki.
  always_ff @(posedge clki) begin
    if (!rstn) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= locked_in;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Next-state, timer and output decode; every output is registered below.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    dom_rstn_d  = dom_rstn_q;
    all_ready_d = all_ready_q;
    lock_lost_d = 1'b0;
    loss_cnt_d  = loss_cnt_q;
    // pll_rst is the registered image of the RESET_PLL state, so it is high
    // for exactly as many cycles as the FSM spends there.
    pll_rst_d   = (state_q == S_RESET_PLL);
    loss_ev     = 1'b0;
`ifdef GLITCH_FILTER_EN
    filt_d      = '0;
`endif

    case (state_q)
      S_RESET_PLL: begin
        // lock_s is deliberately ignored while the PLL is held in reset.
        dom_rstn_d  = '0;
        all_ready_d = 1'b0;
        if (tmr_q == PLL_LAST) begin
          state_d = S_WAIT_LOCK;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_WAIT_LOCK: begin
        dom_rstn_d  = '0;
        all_ready_d = 1'b0;
        // Lock arriving on the timeout cycle still wins over the retry.
        if (lock_s_q) begin
          state_d = S_STABILIZE;
          tmr_d   = '0;
        end else if (tmr_q == TMO_LAST) begin
          state_d = S_RESET_PLL;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_STABILIZE: begin
        // A drop here is just an unstable PLL, not a loss: restart the wait.
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          tmr_d   = '0;
        end else if (tmr_q == STB_LAST) begin
          state_d = S_RELEASE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_RELEASE: begin
        if (loss_det) begin
          loss_ev = 1'b1;
        end else begin
          // Domain i comes out of reset at stage-timer value i*STAGE_GAP.
          for (int i = 0; i < NUM_DOM; i++) begin
            if (tmr_q == TMR_W'(i * STAGE_GAP)) begin
              dom_rstn_d[i] = 1'b1;
            end
          end
          if (tmr_q == REL_LAST) begin
            state_d     = S_RUN;
            all_ready_d = 1'b1;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end

      S_RUN: begin
        if (loss_det) begin
          loss_ev = 1'b1;
        end
      end

      default: begin
        state_d     = S_RESET_PLL;
        tmr_d       = '0;
        dom_rstn_d  = '0;
        all_ready_d = 1'b0;
      end
    endcase

`ifdef GLITCH_FILTER_EN
    // Debounce counter only runs while domains are (being) released.
    if ((state_q == S_RELEASE || state_q == S_RUN) && !lock_s_q && !loss_ev) begin
      filt_d = filt_q + 1'b1;
    end
`endif

    // A loss drops every domain at once and goes back to waiting for lock.
    if (loss_ev) begin
      state_d     = S_WAIT_LOCK;
      tmr_d       = '0;
      dom_rstn_d  = '0;
      all_ready_d = 1'b0;
      lock_lost_d = 1'b1;
    end

    // A clear coinciding with a loss leaves that loss counted.
    if (clr_count) begin
      loss_cnt_d = loss_ev ? LOSS_CNT_W'(1) : '0;
    end else if (loss_ev && !(&loss_cnt_q)) begin
      loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
    end
  end

  // State, timer and output registers with synchronous active-low reset.
  always_ff @(posedge clki) begin
    if (!rstn) begin
      state_q     <= S_RESET_PLL;
      tmr_q       <= '0;
      pll_rst_q   <= 1'b0;
      dom_rstn_q  <= '0;
      all_ready_q <= 1'b0;
      lock_lost_q <= 1'b0;
      loss_cnt_q  <= '0;
`ifdef GLITCH_FILTER_EN
      filt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      pll_rst_q   <= pll_rst_d;
      dom_rstn_q  <= dom_rstn_d;
      all_ready_q <= all_ready_d;
      lock_lost_q <= lock_lost_d;
      loss_cnt_q  <= loss_cnt_d;
`ifdef GLITCH_FILTER_EN
      filt_q      <= filt_d;
`endif
    end
  end

  assign pll_rst    = pll_rst_q;
  assign dom_rstn   = dom_rstn_q;
  assign all_ready  = all_ready_q;
  assign lock_lost  = lock_lost_q;
  assign loss_count = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Purpose: scoreboard bench for pll_lock_supervisor; expected output changes are queued with their edge number.
// Latency: every queued event names the exact clki edge after which the outputs must take the new value.
// Backpressure: none; any output change with no queued event is a miscompare.
module tb_pll_lock_supervisor;

  localparam int NUM_DOM = 3;
  localparam int LCW     = 8;
`ifdef GLITCH_FILTER_EN
  localparam int DROP = 4;
`else
  localparam int DROP = 1;
`endif

  logic               clki = 1'b0;
  logic               rstn = 1'b0;
  logic               locked_in = 1'b0;
  logic               clr_count = 1'b0;
  logic               pll_rst;
  logic [NUM_DOM-1:0] dom_rstn;
  logic               all_ready;
  logic               lock_lost;
  logic [LCW-1:0]     loss_count;

  always #5 clki = ~clki;

  pll_lock_supervisor #(
    .NUM_DOM(NUM_DOM), .STABLE_CYCLES(8), .STAGE_GAP(4), .LOCK_TIMEOUT(20),
    .PLLRST_CYCLES(2), .LOSS_CNT_W(LCW), .FILTER_CYCLES(4)
  ) dut (
    .clki(clki), .rstn(rstn), .locked_in(locked_in), .clr_count(clr_count),
    .pll_rst(pll_rst), .dom_rstn(dom_rstn), .all_ready(all_ready),
    .lock_lost(lock_lost), .loss_count(loss_count)
  );

  typedef struct {
    int          e;
    logic [13:0] v;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_ev;
  int          edge_n  = 0;
  int          n_vec   = 0;
  int          n_mis   = 0;
  int          exp_cnt = 0;
  logic [13:0] prev_v  = '0;
  logic [13:0] cur_v;

  assign cur_v = {pll_rst, dom_rstn, all_ready, lock_lost, loss_count};

  function automatic logic [13:0] mk(input logic p, input logic [2:0] d, input logic a,
                                     input logic l, input logic [7:0] c);
    return {p, d, a, l, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic push(input int e, input logic [13:0] v);
    ev_t t;
    t.e = e;
    t.v = v;
    exp_q.push_back(t);
  endtask

  task automatic wait_to(input int e);
    while (edge_n < e) @(negedge clki);
  endtask

  // Sample just after every edge; compare each output change against the queue.
  always @(posedge clki) begin
    #1;
    edge_n = edge_n + 1;
    if (cur_v !== prev_v) begin
      if (exp_q.size() == 0) begin
        chk("spurious_change", 32'(cur_v), 32'(prev_v));
      end else begin
        mon_ev = exp_q.pop_front();
        chk("event_edge", 32'(edge_n), 32'(mon_ev.e));
        chk("event_value", 32'(cur_v), 32'(mon_ev.v));
      end
    end
    prev_v = cur_v;
  end

  // Lock drop of DROP cycles in RUN: loss, relock and full staged release.
  task automatic do_loss(input bit with_clr);
    int n, l;
    n = edge_n;
    l = n + DROP + 2;
    if (with_clr) exp_cnt = 1;
    else if (exp_cnt < 255) exp_cnt++;
    push(l,      mk(1'b0, 3'b000, 1'b0, 1'b1, 8'(exp_cnt)));
    push(l + 1,  mk(1'b0, 3'b000, 1'b0, 1'b0, 8'(exp_cnt)));
    push(l + 10, mk(1'b0, 3'b001, 1'b0, 1'b0, 8'(exp_cnt)));
    push(l + 14, mk(1'b0, 3'b011, 1'b0, 1'b0, 8'(exp_cnt)));
    push(l + 18, mk(1'b0, 3'b111, 1'b1, 1'b0, 8'(exp_cnt)));
    locked_in = 1'b0;
    repeat (DROP) @(negedge clki);
    locked_in = 1'b1;
    if (with_clr) begin
      wait_to(l - 1);
      clr_count = 1'b1;
      @(negedge clki);
      clr_count = 1'b0;
    end
    wait_to(l + 20);
  endtask

  // Loss, then a drop after 5 STABILIZE cycles, then rstn low while dom_rstn=011.
  task automatic stab_drop_then_reset();
    int n, l, m;
    n = edge_n;
    l = n + DROP + 2;
    m = l + 3;
    if (exp_cnt < 255) exp_cnt++;
    push(l,      mk(1'b0, 3'b000, 1'b0, 1'b1, 8'(exp_cnt)));
    push(l + 1,  mk(1'b0, 3'b000, 1'b0, 1'b0, 8'(exp_cnt)));
    push(m + 13, mk(1'b0, 3'b001, 1'b0, 1'b0, 8'(exp_cnt)));
    push(m + 17, mk(1'b0, 3'b011, 1'b0, 1'b0, 8'(exp_cnt)));
    push(m + 19, mk(1'b0, 3'b000, 1'b0, 1'b0, 8'd0));
    locked_in = 1'b0;
    repeat (DROP) @(negedge clki);
    locked_in = 1'b1;
    wait_to(m);
    locked_in = 1'b0;
    @(negedge clki);
    locked_in = 1'b1;
    wait_to(m + 10);
    chk("stab_drop_count", 32'(loss_count), 32'(exp_cnt));
    wait_to(m + 18);
    chk("release_mid_dom", 32'(dom_rstn), 32'(3'b011));
    rstn = 1'b0;
    exp_cnt = 0;
    @(negedge clki);
    chk("reset_mid_release", 32'(cur_v), 32'(0));
    repeat (2) @(negedge clki);
  endtask

  initial begin
    int e0;
    repeat (4) @(negedge clki);
    chk("reset_outputs", 32'(cur_v), 32'(0));

    // No lock at all: pll_rst retried every 22 cycles, domains stay in reset.
    e0 = edge_n;
    for (int k = 0; k < 3; k++) begin
      push(e0 + 1 + 22 * k, mk(1'b1, 3'b000, 1'b0, 1'b0, 8'd0));
      push(e0 + 3 + 22 * k, mk(1'b0, 3'b000, 1'b0, 1'b0, 8'd0));
    end
    rstn = 1'b1;
    wait_to(e0 + 50);
    chk("nolock_dom", 32'(dom_rstn), 32'(0));
    chk("nolock_count", 32'(loss_count), 32'(0));
    rstn = 1'b0;
    locked_in = 1'b1;
    repeat (3) @(negedge clki);

    // Cold start with lock present from reset release.
    e0 = edge_n;
    push(e0 + 1,  mk(1'b1, 3'b000, 1'b0, 1'b0, 8'd0));
    push(e0 + 3,  mk(1'b0, 3'b000, 1'b0, 1'b0, 8'd0));
    push(e0 + 12, mk(1'b0, 3'b001, 1'b0, 1'b0, 8'd0));
    push(e0 + 16, mk(1'b0, 3'b011, 1'b0, 1'b0, 8'd0));
    push(e0 + 20, mk(1'b0, 3'b111, 1'b1, 1'b0, 8'd0));
    rstn = 1'b1;
    wait_to(e0 + 24);
    chk("cold_all_ready", 32'(all_ready), 32'(1));

`ifdef GLITCH_FILTER_EN
    // Three low cycles are shorter than the debounce: nothing may change.
    locked_in = 1'b0;
    repeat (3) @(negedge clki);
    locked_in = 1'b1;
    repeat (10) @(negedge clki);
    chk("glitch_ignored", 32'(cur_v), 32'(mk(1'b0, 3'b111, 1'b1, 1'b0, 8'd0)));
`endif

    do_loss(1'b0);
    chk("first_loss_count", 32'(loss_count), 32'(1));
    for (int i = 0; i < 259; i++) do_loss(1'b0);
    chk("loss_count_sat", 32'(loss_count), 32'(255));
    do_loss(1'b1);
    chk("clr_with_loss", 32'(loss_count), 32'(1));

    stab_drop_then_reset();

    repeat (5) @(negedge clki);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
